otter_div_unit: RTL

Iterative RV32M divide/remainder unit for the OTTER execute stage, placed beside the ALU. It is fed by the same operand muxes that drive the ALU A/B inputs. It executes DIV, DIVU, REM and REMU with a start/busy/done handshake. Its result is muxed with the ALU output ahead of writeback, and the hazard/stall logic holds the pipeline while `busy` is high.

---
 rtl/otter_mdu_pkg.sv | 27 ++
 rtl/otter_div_step.sv | 23 ++
 rtl/otter_div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/otter_mdu_pkg.sv
// Shared types and constants for the OTTER multiply/divide unit.
package otter_mdu_pkg;

  // Encoding follows func3[1:0] of the M-extension divide instructions.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } div_state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

  // Two's-complement magnitude for signed ops; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] opMagnitude(input logic [31:0] value, input logic isNeg);
    return isNeg ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/otter_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module otter_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qBit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // The shifted value is below twice the divisor, so bit XLEN of the 33-bit difference is a clean borrow flag.
  always_comb begin
    w_shift = {i_rem, i_msb};
    w_diff  = w_shift - {1'b0, i_divisor};
    o_qBit  = ~w_diff[XLEN];
    o_rem   = o_qBit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  end

endmodule

// File: rtl/otter_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake.
module otter_div_unit
  import otter_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  div_state_t      r_state;
  div_state_t      w_nextState;
  div_op_t         r_op;
  logic            r_negA;
  logic            r_negB;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_count;

  logic            w_signedOp;
  logic            w_aNeg;
  logic            w_bNeg;
  logic            w_special;
  logic [XLEN-1:0] w_specialResult;
  logic [XLEN-1:0] w_remNext;
  logic            w_qBit;
  logic [XLEN-1:0] w_quoFinal;
  logic [XLEN-1:0] w_remFinal;
  logic [XLEN-1:0] w_fixed;

  otter_div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_msb     (r_quo[XLEN-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_remNext),
    .o_qBit    (w_qBit)
  );

  assign result = r_result;

  // Decode the incoming request: operand signs and the divide-by-zero / overflow bypass results.
  always_comb begin
    w_signedOp      = ~op[0];
    w_aNeg          = w_signedOp & A[XLEN-1];
    w_bNeg          = w_signedOp & B[XLEN-1];
    w_special       = 1'b0;
    w_specialResult = '0;
    if (B == '0) begin
      w_special       = 1'b1;
      w_specialResult = op[1] ? A : NEG_ONE;
    end else if (w_signedOp && (A == INT_MIN) && (B == NEG_ONE)) begin
      w_special       = 1'b1;
      w_specialResult = op[1] ? '0 : INT_MIN;
    end
  end

  // Final sign fix-up, evaluated on the last iteration so the result is registered as FINISH begins.
  always_comb begin
    w_quoFinal = {r_quo[XLEN-2:0], w_qBit};
    w_remFinal = w_remNext;
    if (r_op == REM || r_op == REMU) begin
      w_fixed = (r_op == REM && r_negA && w_remFinal != '0) ? ('0 - w_remFinal) : w_remFinal;
    end else begin
      w_fixed = (r_op == DIV && (r_negA ^ r_negB)) ? ('0 - w_quoFinal) : w_quoFinal;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = w_special ? FINISH : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == 5'd0) w_nextState = FINISH;
      end
      FINISH: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, load the result when entering FINISH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op      <= DIV;
      r_negA    <= 1'b0;
      r_negB    <= 1'b0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op      <= div_op_t'(op);
            r_negA    <= w_aNeg;
            r_negB    <= w_bNeg;
            r_divisor <= opMagnitude(B, w_bNeg);
            r_quo     <= opMagnitude(A, w_aNeg);
            r_rem     <= '0;
            r_count   <= 5'(DIV_ITERS - 1);
            if (w_special) r_result <= w_specialResult;
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_quo <= {r_quo[XLEN-2:0], w_qBit};
          if (r_count != 5'd0) r_count <= r_count - 5'd1;
          else                 r_result <= w_fixed;
        end
        default: ;
      endcase
    end
  end

endmodule
